autotest_sequencer: RTL and testbench
=====================================

AUTOTEST_SEQUENCER -- requirements
Module: autotest_sequencer

Parameters
REQ-001 The block SHALL have parameter BLOCK_W, default 64, meaning the cipher block width in bits.
REQ-002 The block SHALL have parameter KEY_W, default 80, meaning the cipher key width in bits; KEY_W >= BLOCK_W is required.
REQ-003 The block SHALL have parameter N_VEC, default 8, meaning the number of test-vector slots (power of two, >= 2); AW = log2(N_VEC).
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning the latency counter width.
REQ-005 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum RUN cycles before abort; TIMEOUT < 2^CNT_W.

Interface
REQ-006 The block SHALL have port clk, input, width 1: single clock for the block and the UUT.
REQ-007 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, width 1: level sampled in IDLE, begins a campaign.
REQ-009 The block SHALL have port busy, output, width 1: high from campaign start until DONE exits.
REQ-010 The block SHALL have port done, output, width 1: one-cycle pulse at campaign end.
REQ-011 The block SHALL have configuration ports cfg_we (in, 1), cfg_addr (in, AW), cfg_sel (in, 2: 0=block_i, 1=key, 2=expected, 3=encdec) and cfg_data (in, KEY_W); block and expected take LSBs, encdec takes bit 0.
REQ-012 The block SHALL have port rd_addr, input, width AW: result read address.
REQ-013 The block SHALL have result ports rd_cycles (out, CNT_W), rd_block (out, BLOCK_W) and rd_status (out, 2: 00=not run, 01=pass, 10=fail, 11=timeout), all combinational from rd_addr.
REQ-014 The block SHALL have ports pass_count and fail_count, output, width AW+1 each; timeouts count as fail.
REQ-015 The block SHALL have UUT drive ports rst_uut (out, 1, active-high), block_i_uut (out, BLOCK_W), key_uut (out, KEY_W) and encdec_uut (out, 1: 0=enc, 1=dec).
REQ-016 The block SHALL have UUT return ports block_o_uut (in, BLOCK_W), end_enc_uut (in, 1) and end_dec_uut (in, 1).

Function
REQ-017 A cfg_we write in IDLE SHALL update field cfg_sel of slot cfg_addr on the next edge; cfg_we while busy SHALL be ignored.
REQ-018 The FSM SHALL have states IDLE, APPLY, RUN, CHECK, NEXT and DONE.
REQ-019 IDLE with start=1 SHALL move to APPLY with slot index 0, clear all rd_status to 00, and zero pass_count and fail_count.
REQ-020 APPLY SHALL drive slot inputs onto block_i_uut, key_uut and encdec_uut, hold rst_uut=1 for exactly 2 cycles, clear the latency counter, then enter RUN.
REQ-021 UUT inputs SHALL stay stable from APPLY through CHECK for the current slot.
REQ-022 In RUN, end flag = end_dec_uut if encdec_uut else end_enc_uut; the counter SHALL increment each cycle the flag is 0.
REQ-023 The first RUN cycle with the flag at 1 SHALL enter CHECK; rd_cycles = cycles counted (0 if the flag is high in the first RUN cycle), and rd_block SHALL capture block_o_uut.
REQ-024 When the counter reaches TIMEOUT with the flag still 0, the FSM SHALL enter CHECK with status 11 and rd_cycles = TIMEOUT; a flag rising on that same cycle SHALL win and be treated as completion.
REQ-025 CHECK SHALL set status 01 and increment pass_count if captured block == expected[BLOCK_W-1:0], else set status 10 (unless already 11) and increment fail_count; duration is one cycle.
REQ-026 NEXT SHALL go to APPLY with index+1, or to DONE when index == N_VEC-1, with no index wrap.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE, with busy deasserting in the same cycle.
REQ-028 start held high in IDLE after done SHALL launch a new campaign; start while busy SHALL be ignored.
REQ-029 Results and the vector memory SHALL persist across campaigns until overwritten.

Reset
REQ-030 rst=0 SHALL, asynchronously and at any state including mid-RUN, force IDLE with busy=0, done=0, rst_uut=1, counters=0, all rd_status=00, UUT data outputs=0 and vector memory=0.
REQ-031 After rst release, rst_uut SHALL be 1 in IDLE and deasserted only by APPLY-to-RUN sequencing.

Verification
REQ-032 Load 8 PRESENT enc vectors (key 0, pt 0, expected 0x5579C1387B228445) with a UUT model ending after 32 cycles, then start -> all status 01, rd_cycles=32, pass_count=8, done pulses once.
REQ-033 Slot 3 expected corrupted -> rd_status[3]=10, pass_count=7, fail_count=1.
REQ-034 Slot 5 with the end flag never rising -> rd_status[5]=11, rd_cycles[5]=1024, and the campaign continues to slot 7.
REQ-035 Mixed encdec: a dec slot with end_enc stuck 1 and end_dec after 40 cycles -> rd_cycles=40.
REQ-036 rst pulsed low mid-RUN of slot 2 -> immediate IDLE, rst_uut=1, statuses=00, memory=0.
REQ-037 cfg_we and start pulsed while busy -> memory unchanged and no restart; the flag high in the first RUN cycle -> rd_cycles=0.

Source files
------------

// File: rtl/autotest_sequencer.sv
// autotest_sequencer
//   Walks N_VEC stored test vectors through an external cipher unit under
//   test (UUT). For each slot it resets the UUT, drives the slot's block,
//   key and direction, and times the UUT's end flag. It then records the
//   latency, the output block and a pass/fail/timeout status.
//
// Ports
//   clk, rst             : clock, asynchronous active-low reset
//   start, busy, done    : campaign control (done is a one-cycle pulse)
//   cfg_we/addr/sel/data : vector memory write port, honoured only in IDLE
//                          (sel 0=block_i, 1=key, 2=expected, 3=encdec)
//   rd_addr -> rd_cycles/rd_block/rd_status : combinational result read
//   pass_count/fail_count: campaign tallies (timeouts count as fail)
//   rst_uut, block_i_uut, key_uut, encdec_uut : drive to the UUT
//   block_o_uut, end_enc_uut, end_dec_uut     : returns from the UUT
module autotest_sequencer #(
  parameter  int BLOCK_W = 64,
  parameter  int KEY_W   = 80,
  parameter  int N_VEC   = 8,
  parameter  int CNT_W   = 32,
  parameter  int TIMEOUT = 1024,
  localparam int AW      = $clog2(N_VEC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [1:0]         cfg_sel,
  input  logic [KEY_W-1:0]   cfg_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [CNT_W-1:0]   rd_cycles,
  output logic [BLOCK_W-1:0] rd_block,
  output logic [1:0]         rd_status,
  output logic [AW:0]        pass_count,
  output logic [AW:0]        fail_count,
  output logic               rst_uut,
  output logic [BLOCK_W-1:0] block_i_uut,
  output logic [KEY_W-1:0]   key_uut,
  output logic               encdec_uut,
  input  logic [BLOCK_W-1:0] block_o_uut,
  input  logic               end_enc_uut,
  input  logic               end_dec_uut
);

  localparam logic [CNT_W-1:0] LP_TO   = CNT_W'(TIMEOUT);
  localparam logic [AW-1:0]    LP_LAST = AW'(N_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_RUN, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t r_state, w_next;

  // Vector memory
  logic [BLOCK_W-1:0] r_m_blk [N_VEC];
  logic [KEY_W-1:0]   r_m_key [N_VEC];
  logic [BLOCK_W-1:0] r_m_exp [N_VEC];
  logic               r_m_ed  [N_VEC];

  // Result memory
  logic [CNT_W-1:0]   r_res_cyc [N_VEC];
  logic [BLOCK_W-1:0] r_res_blk [N_VEC];
  logic [1:0]         r_res_st  [N_VEC];

  logic [AW-1:0]      r_idx;
  logic               r_apc;      // second APPLY cycle
  logic [CNT_W-1:0]   r_cnt;
  logic               r_to;       // current slot timed out
  logic [AW:0]        r_pass, r_fail;
  logic [BLOCK_W-1:0] r_blk_i;
  logic [KEY_W-1:0]   r_key;
  logic               r_ed;

  logic               w_flag;
  logic               w_load;
  logic [AW-1:0]      w_ld_idx;

  assign w_flag   = r_ed ? end_dec_uut : end_enc_uut;
  // UUT drive registers load on entry to APPLY so they are already valid
  // in the first APPLY cycle and hold through CHECK.
  assign w_load   = (w_next == S_APPLY) && (r_state != S_APPLY);
  assign w_ld_idx = (r_state == S_IDLE) ? '0 : r_idx + AW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    // UUT reset is released only for RUN/CHECK/NEXT, giving exactly two
    // asserted cycles (the APPLY pair) between consecutive slots.
    rst_uut = (r_state == S_IDLE) || (r_state == S_APPLY) || (r_state == S_DONE);
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_APPLY;
      S_APPLY: if (r_apc) w_next = S_RUN;
      S_RUN:   if (w_flag || (r_cnt == LP_TO)) w_next = S_CHECK;
      S_CHECK: w_next = S_NEXT;
      S_NEXT:  w_next = (r_idx == LP_LAST) ? S_DONE : S_APPLY;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_apc   <= 1'b0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_blk_i <= '0;
      r_key   <= '0;
      r_ed    <= 1'b0;
      for (int unsigned i = 0; i < N_VEC; i++) begin
        r_m_blk[i]   <= '0;
        r_m_key[i]   <= '0;
        r_m_exp[i]   <= '0;
        r_m_ed[i]    <= 1'b0;
        r_res_cyc[i] <= '0;
        r_res_blk[i] <= '0;
        r_res_st[i]  <= 2'b00;
      end
    end else begin
      if ((r_state == S_IDLE) && cfg_we) begin
        unique case (cfg_sel)
          2'd0: r_m_blk[cfg_addr] <= cfg_data[BLOCK_W-1:0];
          2'd1: r_m_key[cfg_addr] <= cfg_data;
          2'd2: r_m_exp[cfg_addr] <= cfg_data[BLOCK_W-1:0];
          2'd3: r_m_ed[cfg_addr]  <= cfg_data[0];
        endcase
      end

      if (w_load) begin
        r_blk_i <= r_m_blk[w_ld_idx];
        r_key   <= r_m_key[w_ld_idx];
        r_ed    <= r_m_ed[w_ld_idx];
      end

      r_apc <= (r_state == S_APPLY) ? ~r_apc : 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx  <= '0;
            r_pass <= '0;
            r_fail <= '0;
            for (int unsigned i = 0; i < N_VEC; i++) r_res_st[i] <= 2'b00;
          end
        end
        S_APPLY: r_cnt <= '0;
        S_RUN: begin
          // A flag arriving on the TIMEOUT cycle counts as completion.
          if (w_flag || (r_cnt == LP_TO)) begin
            r_res_cyc[r_idx] <= r_cnt;
            r_res_blk[r_idx] <= block_o_uut;
            r_to             <= ~w_flag;
            if (!w_flag) r_res_st[r_idx] <= 2'b11;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (r_to) begin
            r_fail <= r_fail + (AW+1)'(1);
          end else if (r_res_blk[r_idx] == r_m_exp[r_idx]) begin
            r_res_st[r_idx] <= 2'b01;
            r_pass          <= r_pass + (AW+1)'(1);
          end else begin
            r_res_st[r_idx] <= 2'b10;
            r_fail          <= r_fail + (AW+1)'(1);
          end
        end
        S_NEXT: if (r_idx != LP_LAST) r_idx <= r_idx + AW'(1);
        default: ;
      endcase
    end
  end

  assign rd_cycles   = r_res_cyc[rd_addr];
  assign rd_block    = r_res_blk[rd_addr];
  assign rd_status   = r_res_st[rd_addr];
  assign pass_count  = r_pass;
  assign fail_count  = r_fail;
  assign block_i_uut = r_blk_i;
  assign key_uut     = r_key;
  assign encdec_uut  = r_ed;

endmodule

// File: tb/tb_autotest_sequencer.sv
// Bench for autotest_sequencer: per-slot vector table with a behavioural UUT
// whose latency/behaviour per slot comes from the same table.
module tb_autotest_sequencer;

  localparam int BW = 64;
  localparam int KW = 80;
  localparam int NV = 8;
  localparam int AW = 3;
  localparam int CW = 32;
  localparam int TO = 1024;
  localparam logic [BW-1:0] C_CT = 64'h5579C1387B228445;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done, cfg_we;
  logic [AW-1:0] cfg_addr, rd_addr;
  logic [1:0]    cfg_sel, rd_status;
  logic [KW-1:0] cfg_data, key_uut;
  logic [CW-1:0] rd_cycles;
  logic [BW-1:0] rd_block, block_i_uut, block_o_uut;
  logic [AW:0]   pass_count, fail_count;
  logic          rst_uut, encdec_uut, end_enc_uut, end_dec_uut;

  autotest_sequencer #(
    .BLOCK_W(BW), .KEY_W(KW), .N_VEC(NV), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .rd_addr(rd_addr), .rd_cycles(rd_cycles), .rd_block(rd_block),
    .rd_status(rd_status), .pass_count(pass_count), .fail_count(fail_count),
    .rst_uut(rst_uut), .block_i_uut(block_i_uut), .key_uut(key_uut),
    .encdec_uut(encdec_uut), .block_o_uut(block_o_uut),
    .end_enc_uut(end_enc_uut), .end_dec_uut(end_dec_uut)
  );

  typedef struct {
    logic [BW-1:0] blk;
    logic [KW-1:0] key;
    logic [BW-1:0] exp;
    logic          ed;
    int            lat;     // UUT cycles until its end flag rises
    bit            never;   // end flag never rises
    bit            stuck;   // end_enc held high during a dec slot
    logic [1:0]    e_st;
    int            e_cyc;
    bit            chk_blk;
  } vec_t;

  vec_t tbl[NV];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Behavioural UUT
  int cur_slot = -1;
  int uut_cnt  = 0;
  logic fin;

  always @(posedge clk) begin
    if (rst_uut) uut_cnt <= 0;
    else         uut_cnt <= uut_cnt + 1;
  end

  always_comb begin
    int k;
    k = (cur_slot < 0 || cur_slot >= NV) ? 0 : cur_slot;
    fin         = !rst_uut && !tbl[k].never && (uut_cnt >= tbl[k].lat);
    end_enc_uut = encdec_uut ? tbl[k].stuck : fin;
    end_dec_uut = encdec_uut ? fin : 1'b0;
    block_o_uut = fin ? C_CT : '0;
  end

  // Monitor: slot tracking, UUT-reset width, stable UUT drive, done width
  int run_hi = 0;
  bit prev_hi = 1'b1;
  bit prev_done = 1'b0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!busy) begin
      cur_slot = -1;
      run_hi   = 0;
    end else begin
      if (!rst_uut && prev_hi) begin
        cur_slot = cur_slot + 1;
        chk("rst_uut_high_cycles", 128'(run_hi), 128'(2));
        run_hi = 0;
      end
      if (rst_uut) run_hi = run_hi + 1;
      if (!rst_uut && cur_slot >= 0 && cur_slot < NV) begin
        chk($sformatf("key_uut_s%0d", cur_slot), 128'(key_uut), 128'(tbl[cur_slot].key));
        chk($sformatf("block_i_uut_s%0d", cur_slot), 128'(block_i_uut), 128'(tbl[cur_slot].blk));
        chk($sformatf("encdec_uut_s%0d", cur_slot), 128'(encdec_uut), 128'(tbl[cur_slot].ed));
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_one_cycle", 128'(prev_done), 128'(0));
    end
    prev_hi   = rst_uut;
    prev_done = done;
  end

  task automatic cfg_write(input int a, input int s, input logic [KW-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_sel = 2'(s); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NV; i++) begin
      cfg_write(i, 0, KW'(tbl[i].blk));
      cfg_write(i, 1, tbl[i].key);
      cfg_write(i, 2, KW'(tbl[i].exp));
      cfg_write(i, 3, KW'(tbl[i].ed));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 128'(done), 128'(1));
  endtask

  task automatic check_results(input string tag);
    int ep = 0, ef = 0;
    for (int i = 0; i < NV; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("%s_status%0d", tag, i), 128'(rd_status), 128'(tbl[i].e_st));
      chk($sformatf("%s_cycles%0d", tag, i), 128'(rd_cycles), 128'(tbl[i].e_cyc));
      if (tbl[i].chk_blk) chk($sformatf("%s_block%0d", tag, i), 128'(rd_block), 128'(C_CT));
      if (tbl[i].e_st == 2'b01) ep++; else ef++;
    end
    chk({tag, "_pass_count"}, 128'(pass_count), 128'(ep));
    chk({tag, "_fail_count"}, 128'(fail_count), 128'(ef));
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_rst_uut"}, 128'(rst_uut), 128'(1));
    chk({tag, "_block_i"}, 128'(block_i_uut), 128'(0));
    chk({tag, "_key"}, 128'(key_uut), 128'(0));
    chk({tag, "_encdec"}, 128'(encdec_uut), 128'(0));
    chk({tag, "_pass"}, 128'(pass_count), 128'(0));
    chk({tag, "_fail"}, 128'(fail_count), 128'(0));
    for (int i = 0; i < NV; i++) begin
      rd_addr = AW'(i);
      #0.1;
      chk($sformatf("%s_status%0d", tag, i), 128'(rd_status), 128'(0));
    end
  endtask

  initial begin
    int d0, n;
    rst = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0;
    cfg_data = '0; rd_addr = '0;
    for (int i = 0; i < NV; i++) begin
      tbl[i].blk = '0; tbl[i].key = '0; tbl[i].exp = C_CT; tbl[i].ed = 1'b0;
      tbl[i].lat = 32; tbl[i].never = 1'b0; tbl[i].stuck = 1'b0;
      tbl[i].e_st = 2'b01; tbl[i].e_cyc = 32; tbl[i].chk_blk = 1'b1;
    end
    #3;
    check_idle_reset("reset");
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Campaign 1: eight identical PRESENT enc vectors, 32-cycle UUT
    load_all();
    d0 = done_cnt;
    pulse_start();
    wait_done(4000);
    @(negedge clk);
    chk("c1_busy_after_done", 128'(busy), 128'(0));
    check_results("c1");
    chk("c1_done_pulses", 128'(done_cnt - d0), 128'(1));

    // Campaign 2: mixed corner cases
    for (int i = 0; i < NV; i++) begin
      tbl[i].blk = BW'(64'h0123_4567_0000_0000 + 64'(i));
      tbl[i].key = KW'(80'hBEEF_0000_0000_0000_0000 + 80'(i * 7 + 1));
    end
    tbl[1].lat = 0;  tbl[1].e_cyc = 0;
    tbl[2].lat = 7;  tbl[2].e_cyc = 7;
    tbl[3].exp = C_CT ^ 64'h1; tbl[3].e_st = 2'b10;
    tbl[5].never = 1'b1; tbl[5].e_st = 2'b11; tbl[5].e_cyc = TO; tbl[5].chk_blk = 1'b0;
    tbl[6].ed = 1'b1; tbl[6].stuck = 1'b1; tbl[6].lat = 40; tbl[6].e_cyc = 40;
    tbl[7].lat = TO; tbl[7].e_cyc = TO;
    load_all();
    d0 = done_cnt;
    pulse_start();
    repeat (3) @(negedge clk);
    rd_addr = AW'(7);
    #1;
    chk("c2_status_cleared_on_start", 128'(rd_status), 128'(0));
    chk("c2_pass_cleared_on_start", 128'(pass_count), 128'(0));
    // Writes and start while busy must be ignored
    cfg_we = 1'b1; cfg_addr = AW'(3); cfg_sel = 2'd2; cfg_data = KW'(C_CT); start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_done(6000);
    @(negedge clk);
    chk("c2_busy_after_done", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    chk("c2_no_restart", 128'(busy), 128'(0));
    check_results("c2");
    chk("c2_done_pulses", 128'(done_cnt - d0), 128'(1));

    // Campaign 3: results persist; start held high relaunches after done
    @(negedge clk); start = 1'b1;
    wait_done(6000);
    check_results("c3");
    @(negedge clk);
    chk("c3_idle_after_done", 128'(busy), 128'(0));
    @(negedge clk);
    chk("c3_relaunch_busy", 128'(busy), 128'(1));
    chk("c3_relaunch_pass_cleared", 128'(pass_count), 128'(0));
    start = 1'b0;

    // Asynchronous reset in the middle of slot 2's RUN
    n = 0;
    while (!(cur_slot == 2 && !rst_uut) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("c4_reached_slot2_run", 128'(cur_slot == 2 && !rst_uut), 128'(1));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_idle_reset("midrun_reset");
    @(negedge clk); rst = 1'b1;

    // Campaign 5: vector memory was cleared, so every slot fails (expected 0)
    for (int i = 0; i < NV; i++) begin
      tbl[i].blk = '0; tbl[i].key = '0; tbl[i].exp = '0; tbl[i].ed = 1'b0;
      tbl[i].lat = 3; tbl[i].never = 1'b0; tbl[i].stuck = 1'b0;
      tbl[i].e_st = 2'b10; tbl[i].e_cyc = 3; tbl[i].chk_blk = 1'b1;
    end
    d0 = done_cnt;
    pulse_start();
    wait_done(2000);
    @(negedge clk);
    check_results("c5");
    chk("c5_done_pulses", 128'(done_cnt - d0), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
